// File: rtl/data_mem_lsu.sv
// Load/store sequencer: splits byte/half/word core requests into little-endian single-byte
// data_memory accesses. Define LSU_BOUNDS_CHECK_EN to reject requests that run past MEM_DEPTH.
module data_mem_lsu #(
  parameter int ADDR_W    = 20,
  parameter int MEM_DEPTH = 614400,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wren,
  output logic [7:0]        mem_data,
  input  logic [7:0]        mem_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("data_mem_lsu: RD_LAT must be in 1..3");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("data_mem_lsu: MEM_DEPTH does not fit the address space");
  end

  state_t state, state_nxt;

  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       wdata_q;
  logic [1:0]        last_idx;
  logic [1:0]        issue_idx;
  logic [1:0]        next_idx;
  logic [31:0]       result;

  logic              cap_vld [1:RD_LAT];
  logic [1:0]        cap_idx [1:RD_LAT];

  logic              accept;
  logic              size_bad;
  logic              range_bad;
  logic              req_bad;
  logic [1:0]        req_n_m1;
  logic              issue_last;
  logic              issuing_load;
  logic              cap_fire;
  logic              cap_last;
  logic [31:0]       cap_result;
  logic [31:0]       load_ext;

  always_comb begin
    req_n_m1 = 2'd0;
    case (req_size)
      2'b01:   req_n_m1 = 2'd1;
      2'b10:   req_n_m1 = 2'd3;
      default: req_n_m1 = 2'd0;
    endcase
  end

`ifdef LSU_BOUNDS_CHECK_EN
  // Last byte address is formed one bit wider so a wrap past 2^ADDR_W still fails the check.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);
  logic [ADDR_W:0] end_addr;
  assign end_addr  = {1'b0, req_addr} + (ADDR_W+1)'(req_n_m1);
  assign range_bad = (end_addr >= DEPTH_L);
`else
  assign range_bad = 1'b0;
`endif

  assign size_bad     = (req_size == 2'b11);
  assign req_bad      = size_bad | range_bad;
  assign req_ready    = (state == IDLE);
  assign accept       = req_valid & req_ready;
  assign issue_last   = (issue_idx == last_idx);
  assign next_idx     = issue_idx + 2'd1;
  assign issuing_load = (state == ISSUE) & ~we_q;
  assign cap_fire     = cap_vld[RD_LAT];
  assign cap_last     = cap_fire & (cap_idx[RD_LAT] == last_idx);

  always_comb begin
    cap_result = result;
    if (cap_fire) begin
      cap_result[{cap_idx[RD_LAT], 3'b000} +: 8] = mem_q;
    end
  end

  always_comb begin
    load_ext = cap_result;
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & cap_result[7]}}, cap_result[7:0]};
      2'b01:   load_ext = {{16{signed_q & cap_result[15]}}, cap_result[15:0]};
      default: load_ext = cap_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_nxt = we_q ? RESP : DRAIN;
        end
      end
      DRAIN: begin
        if (cap_last) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-return tracker: each load byte issued is tagged and emerges RD_LAT cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 1; j <= RD_LAT; j++) begin
        cap_vld[j] <= 1'b0;
        cap_idx[j] <= 2'd0;
      end
    end else begin
      cap_vld[1] <= issuing_load;
      cap_idx[1] <= issue_idx;
      for (int j = 2; j <= RD_LAT; j++) begin
        cap_vld[j] <= cap_vld[j-1];
        cap_idx[j] <= cap_idx[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      base_addr   <= '0;
      wdata_q     <= 32'd0;
      last_idx    <= 2'd0;
      issue_idx   <= 2'd0;
      result      <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      mem_address <= '0;
      mem_wren    <= 1'b0;
      mem_data    <= 8'd0;
    end else begin
      rsp_valid <= (state_nxt == RESP);
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      if (cap_fire) begin
        result <= cap_result;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            size_q    <= req_size;
            signed_q  <= req_signed;
            base_addr <= req_addr;
            wdata_q   <= req_wdata;
            last_idx  <= req_n_m1;
            issue_idx <= 2'd0;
            result    <= 32'd0;
            if (req_bad) begin
              rsp_err <= 1'b1;
            end else begin
              mem_address <= req_addr;
              mem_wren    <= req_we;
              mem_data    <= req_wdata[7:0];
            end
          end
        end
        ISSUE: begin
          if (issue_last) begin
            mem_wren <= 1'b0;
          end else begin
            issue_idx   <= next_idx;
            mem_address <= base_addr + ADDR_W'(next_idx);
            mem_wren    <= we_q;
            mem_data    <= wdata_q[{next_idx, 3'b000} +: 8];
          end
        end
        DRAIN: begin
          if (cap_last) begin
            rsp_rdata <= load_ext;
          end
        end
        default: begin
          mem_wren <= 1'b0;
        end
      endcase
    end
  end

endmodule
